// File: rtl/spi_cmd_queue_mc.sv
// Multi-channel SPI command queue: N_CH show-ahead FIFOs merged by a lockable round-robin or fixed-priority arbiter.
// Optional sticky overflow/underflow flags when SPI_CMDQ_ERR_EN is defined.
module spi_cmd_queue_mc #(
   parameter int DATA_W   = 136,
   parameter int DEPTH    = 8,
   parameter int N_CH     = 2,
   parameter int AF_LEVEL = 6,
   parameter int ARB_MODE = 0,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [N_CH-1:0]          i_in_push,
   input  logic [N_CH*DATA_W-1:0]   i_in_data,
   output logic [N_CH-1:0]          o_in_ready,
   output logic [N_CH-1:0]          o_in_almost_full,
   input  logic [N_CH-1:0]          i_flush,
   output logic [N_CH*(AW+1)-1:0]   o_level,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [DATA_W-1:0]        o_out_data,
   output logic [CW-1:0]            o_out_ch
`ifdef SPI_CMDQ_ERR_EN
  ,output logic [N_CH-1:0]          o_err_ovf,
   output logic                     o_err_unf,
   input  logic                     i_err_clr,
   input  logic                     i_expect_valid
`endif
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_LEVEL);
   localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

   typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} arb_st_t;

   logic [DATA_W-1:0] r_mem   [N_CH][DEPTH];
   logic [AW:0]       r_wptr  [N_CH];
   logic [AW:0]       r_rptr  [N_CH];
   logic [AW:0]       r_level [N_CH];

   logic [N_CH-1:0]   w_full;
   logic [N_CH-1:0]   w_nempty;
   logic [N_CH-1:0]   w_push_ok;
   logic [N_CH-1:0]   w_pop_ch;
   logic [CW-1:0]     w_free_grant;
   logic [CW-1:0]     w_grant;
   logic [CW-1:0]     r_grant;
   logic [CW-1:0]     r_rr;
   logic              w_valid;
   logic              w_pop;
   arb_st_t           r_st;

   // Per-channel status derived only from registered pointers and levels
   always_comb begin
      w_full           = '0;
      w_nempty         = '0;
      w_push_ok        = '0;
      o_level          = '0;
      o_in_almost_full = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_nempty[c]  = (r_wptr[c] != r_rptr[c]);
         w_full[c]    = (r_wptr[c][AW] != r_rptr[c][AW]) &&
                        (r_wptr[c][AW-1:0] == r_rptr[c][AW-1:0]);
         // Flush wins over a same-cycle push
         w_push_ok[c] = i_in_push[c] && !w_full[c] && !i_flush[c];
         o_level[c*(AW+1) +: (AW+1)] = r_level[c];
         o_in_almost_full[c]         = (r_level[c] >= AF_LVL);
      end
      o_in_ready = ~w_full;
   end

   // Free-running arbitration plus lock override
   always_comb begin
      logic found;
      int   idx;
      found        = 1'b0;
      idx          = 0;
      w_free_grant = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (ARB_MODE == 0) begin
            idx = (int'(r_rr) + k) % N_CH;
         end else begin
            idx = k;
         end
         if (!found && w_nempty[idx]) begin
            found        = 1'b1;
            w_free_grant = CW'(idx);
         end else begin
            found = found;
         end
      end
      w_grant = (r_st == ST_LOCKED) ? r_grant : w_free_grant;
      w_valid = |w_nempty;
      w_pop   = w_valid && i_out_ready;
   end

   // Show-ahead output mux and per-channel pop decode
   always_comb begin
      w_pop_ch = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_pop_ch[c] = w_pop && (w_grant == CW'(c));
      end
      o_out_valid = w_valid;
      if (w_valid) begin
         o_out_ch   = w_grant;
         o_out_data = r_mem[w_grant][r_rptr[w_grant][AW-1:0]];
      end else begin
         o_out_ch   = '0;
         o_out_data = '0;
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge i_clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (w_push_ok[c]) begin
            r_mem[c][r_wptr[c][AW-1:0]] <= i_in_data[c*DATA_W +: DATA_W];
         end
      end
   end

   // Pointer and level bookkeeping
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int c = 0; c < N_CH; c++) begin
            r_wptr[c]  <= '0;
            r_rptr[c]  <= '0;
            r_level[c] <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_push_ok[c]) begin
               r_wptr[c] <= r_wptr[c] + PTR_ONE;
            end
            if (i_flush[c]) begin
               r_rptr[c]  <= r_wptr[c];
               r_level[c] <= '0;
            end else begin
               if (w_pop_ch[c]) begin
                  r_rptr[c] <= r_rptr[c] + PTR_ONE;
               end
               case ({w_push_ok[c], w_pop_ch[c]})
                  2'b10:   r_level[c] <= r_level[c] + PTR_ONE;
                  2'b01:   r_level[c] <= r_level[c] - PTR_ONE;
                  default: r_level[c] <= r_level[c];
               endcase
            end
         end
      end
   end

   // Grant lock FSM and round-robin pointer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_st    <= ST_FREE;
         r_grant <= '0;
         r_rr    <= '0;
      end else begin
         case (r_st)
            ST_FREE: begin
               // Never lock onto a channel that is being flushed this cycle
               if (w_valid && !i_out_ready && !i_flush[w_free_grant]) begin
                  r_st    <= ST_LOCKED;
                  r_grant <= w_free_grant;
               end else begin
                  r_st <= ST_FREE;
               end
            end
            ST_LOCKED: begin
               if (w_pop || i_flush[r_grant]) begin
                  r_st <= ST_FREE;
               end else begin
                  r_st <= ST_LOCKED;
               end
            end
            default: r_st <= ST_FREE;
         endcase
         if (w_pop) begin
            r_rr <= (w_grant == LAST_CH) ? '0 : w_grant + CW'(1);
         end
      end
   end

`ifdef SPI_CMDQ_ERR_EN
   // Sticky error flags
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_err_ovf <= '0;
         o_err_unf <= 1'b0;
      end else if (i_err_clr) begin
         o_err_ovf <= '0;
         o_err_unf <= 1'b0;
      end else begin
         o_err_ovf <= o_err_ovf | (i_in_push & w_full);
         o_err_unf <= o_err_unf | (i_out_ready && !w_valid && i_expect_valid);
      end
   end
`endif

endmodule

// File: tb/tb_spi_cmd_queue_mc.sv
// Scoreboard bench for spi_cmd_queue_mc: a round-robin instance (main) and a fixed-priority instance (fp).
module tb_spi_cmd_queue_mc;
   localparam int DW = 136;
   localparam int NC = 3;
   localparam int LW = 4;

   typedef struct packed {
      logic [1:0]    ch;
      logic [DW-1:0] data;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NC-1:0]    m_push = '0, m_flush = '0, m_rdy, m_af;
   logic [NC*DW-1:0] m_data = '0;
   logic [NC*LW-1:0] m_level;
   logic             m_ovalid, m_ordy = 1'b0;
   logic [DW-1:0]    m_odata;
   logic [1:0]       m_och;

   logic [NC-1:0]    f_push = '0, f_flush = '0, f_rdy, f_af;
   logic [NC*DW-1:0] f_data = '0;
   logic [NC*3-1:0]  f_level;
   logic             f_ovalid, f_ordy = 1'b0;
   logic [DW-1:0]    f_odata;
   logic [1:0]       f_och;

`ifdef SPI_CMDQ_ERR_EN
   logic [NC-1:0] m_ovf, f_ovf;
   logic          m_unf, f_unf;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t mq[$];
   exp_t fq[$];

   always #5 clk = ~clk;

   spi_cmd_queue_mc #(.DATA_W(DW), .DEPTH(8), .N_CH(NC), .AF_LEVEL(6), .ARB_MODE(0)) u_main (
      .i_clk(clk), .i_rst(rst), .i_in_push(m_push), .i_in_data(m_data),
      .o_in_ready(m_rdy), .o_in_almost_full(m_af), .i_flush(m_flush), .o_level(m_level),
      .o_out_valid(m_ovalid), .i_out_ready(m_ordy), .o_out_data(m_odata), .o_out_ch(m_och)
`ifdef SPI_CMDQ_ERR_EN
     ,.o_err_ovf(m_ovf), .o_err_unf(m_unf), .i_err_clr(1'b0), .i_expect_valid(1'b0)
`endif
   );

   spi_cmd_queue_mc #(.DATA_W(DW), .DEPTH(4), .N_CH(NC), .AF_LEVEL(4), .ARB_MODE(1)) u_fp (
      .i_clk(clk), .i_rst(rst), .i_in_push(f_push), .i_in_data(f_data),
      .o_in_ready(f_rdy), .o_in_almost_full(f_af), .i_flush(f_flush), .o_level(f_level),
      .o_out_valid(f_ovalid), .i_out_ready(f_ordy), .o_out_data(f_odata), .o_out_ch(f_och)
`ifdef SPI_CMDQ_ERR_EN
     ,.o_err_ovf(f_ovf), .o_err_unf(f_unf), .i_err_clr(1'b0), .i_expect_valid(1'b0)
`endif
   );

   function automatic logic [DW-1:0] wd(logic [7:0] tag, int n);
      return {tag, 128'(n)};
   endfunction

   function automatic logic [LW-1:0] lvl(int c);
      return m_level[c*LW +: LW];
   endfunction

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_push  = '0;
      m_flush = '0;
      f_push  = '0;
   endtask

   task automatic mpush(int ch, logic [DW-1:0] w);
      m_push[ch]           = 1'b1;
      m_data[ch*DW +: DW]  = w;
   endtask

   task automatic fpush(int ch, logic [DW-1:0] w);
      f_push[ch]           = 1'b1;
      f_data[ch*DW +: DW]  = w;
   endtask

   task automatic mexp(int ch, logic [DW-1:0] w);
      mq.push_back('{ch: 2'(ch), data: w});
   endtask

   task automatic fexp(int ch, logic [DW-1:0] w);
      fq.push_back('{ch: 2'(ch), data: w});
   endtask

   // Main-instance monitor: every accepted word must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && m_ovalid && m_ordy) begin
         exp_t e;
         total++;
         if (mq.size() == 0) begin
            bad++;
            $display("FAIL main_sb_unexpected act_ch=%0d act=%h exp=none", m_och, m_odata);
         end else begin
            e = mq.pop_front();
            if (m_och !== e.ch || m_odata !== e.data) begin
               bad++;
               $display("FAIL main_sb act_ch=%0d act=%h exp_ch=%0d exp=%h", m_och, m_odata, e.ch, e.data);
            end
         end
      end
   end

   // Fixed-priority-instance monitor
   always @(negedge clk) begin
      if (!rst && f_ovalid && f_ordy) begin
         exp_t e;
         total++;
         if (fq.size() == 0) begin
            bad++;
            $display("FAIL fp_sb_unexpected act_ch=%0d act=%h exp=none", f_och, f_odata);
         end else begin
            e = fq.pop_front();
            if (f_och !== e.ch || f_odata !== e.data) begin
               bad++;
               $display("FAIL fp_sb act_ch=%0d act=%h exp_ch=%0d exp=%h", f_och, f_odata, e.ch, e.data);
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] a5w;
      int            lv;
      a5w = {17{8'hA5}};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", DW'(m_ovalid), DW'(0));
      chk("rst_ready", DW'(m_rdy), DW'(3'b111));
      chk("rst_af", DW'(m_af), DW'(0));
      chk("rst_level", DW'(m_level), DW'(0));
      chk("rst_data", m_odata, DW'(0));
      chk("rst_ch", DW'(m_och), DW'(0));
      rst = 1'b0;
      tick();

      // Single word through ch0
      mpush(0, a5w);
      chk("t1_pre_valid", DW'(m_ovalid), DW'(0));
      tick();
      chk("t1_valid", DW'(m_ovalid), DW'(1));
      chk("t1_ch", DW'(m_och), DW'(0));
      chk("t1_data", m_odata, a5w);
      chk("t1_level", DW'(lvl(0)), DW'(1));
      mexp(0, a5w);
      m_ordy = 1'b1;
      tick();
      m_ordy = 1'b0;
      chk("t1_post_valid", DW'(m_ovalid), DW'(0));
      chk("t1_post_level", DW'(lvl(0)), DW'(0));

      // Fill ch1 past full
      for (int k = 1; k <= 9; k++) begin
         mpush(1, wd(8'h11, k));
         tick();
         lv = (k < 8) ? k : 8;
         chk($sformatf("t2_level_%0d", k), DW'(lvl(1)), DW'(lv));
         chk($sformatf("t2_ready_%0d", k), DW'(m_rdy[1]), DW'(k < 8));
         chk($sformatf("t2_af_%0d", k), DW'(m_af[1]), DW'(lv >= 6));
      end
      for (int k = 1; k <= 8; k++) mexp(1, wd(8'h11, k));
      m_ordy = 1'b1;
      repeat (8) tick();
      m_ordy = 1'b0;
      chk("t2_drained_level", DW'(lvl(1)), DW'(0));
      chk("t2_drained_valid", DW'(m_ovalid), DW'(0));

      // Round robin from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < NC; c++) mpush(c, wd(8'h30 + 8'(c), r));
         tick();
      end
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NC; c++) mexp(c, wd(8'h30 + 8'(c), r));
      m_ordy = 1'b1;
      repeat (6) tick();
      m_ordy = 1'b0;
      chk("t3_empty", DW'(m_ovalid), DW'(0));

      // Fixed priority: lock holds ch2 against a later ch0 push
      fpush(2, wd(8'hC2, 1));
      tick();
      chk("t4_ch_first", DW'(f_och), DW'(2));
      fpush(0, wd(8'hC0, 1));
      tick();
      chk("t4_ch_hold1", DW'(f_och), DW'(2));
      chk("t4_data_hold1", f_odata, wd(8'hC2, 1));
      tick();
      chk("t4_ch_hold2", DW'(f_och), DW'(2));
      chk("t4_data_hold2", f_odata, wd(8'hC2, 1));
      fexp(2, wd(8'hC2, 1));
      fexp(0, wd(8'hC0, 1));
      f_ordy = 1'b1;
      repeat (2) tick();
      f_ordy = 1'b0;

      // Fixed priority keeps serving the lowest channel
      fpush(1, wd(8'hD1, 1));
      fpush(2, wd(8'hD2, 1));
      tick();
      fpush(1, wd(8'hD1, 2));
      tick();
      fexp(1, wd(8'hD1, 1));
      fexp(1, wd(8'hD1, 2));
      fexp(2, wd(8'hD2, 1));
      f_ordy = 1'b1;
      repeat (3) tick();
      f_ordy = 1'b0;
      chk("t5_fp_empty", DW'(f_ovalid), DW'(0));

      // Flush the locked channel with a colliding push
      mpush(0, wd(8'hF0, 1));
      tick();
      mpush(0, wd(8'hF0, 2));
      mpush(1, wd(8'hF1, 1));
      tick();
      mpush(0, wd(8'hF0, 3));
      tick();
      chk("t6_lock_ch", DW'(m_och), DW'(0));
      chk("t6_level0", DW'(lvl(0)), DW'(3));
      mpush(0, wd(8'hF0, 4));
      m_flush[0] = 1'b1;
      tick();
      chk("t6_flush_level", DW'(lvl(0)), DW'(0));
      chk("t6_flush_valid", DW'(m_ovalid), DW'(1));
      chk("t6_flush_ch", DW'(m_och), DW'(1));
      chk("t6_flush_data", m_odata, wd(8'hF1, 1));
      tick();
      chk("t6_push_dropped", DW'(lvl(0)), DW'(0));
      mexp(1, wd(8'hF1, 1));
      m_ordy = 1'b1;
      tick();
      m_ordy = 1'b0;
      chk("t6_empty", DW'(m_ovalid), DW'(0));

      // Simultaneous push and pop at level 4, then async reset mid-burst
      for (int k = 1; k <= 4; k++) begin
         mpush(1, wd(8'hE1, k));
         tick();
      end
      chk("t7_level4", DW'(lvl(1)), DW'(4));
      mexp(1, wd(8'hE1, 1));
      mpush(1, wd(8'hE1, 5));
      m_ordy = 1'b1;
      tick();
      m_ordy = 1'b0;
      chk("t7_level_same", DW'(lvl(1)), DW'(4));
      mpush(1, wd(8'hE1, 6));
      tick();
      mpush(1, wd(8'hE1, 7));
      #2;
      rst = 1'b1;
      #1;
      chk("t7_arst_valid", DW'(m_ovalid), DW'(0));
      chk("t7_arst_level", DW'(m_level), DW'(0));
      chk("t7_arst_ready", DW'(m_rdy), DW'(3'b111));
      chk("t7_arst_af", DW'(m_af), DW'(0));
      chk("t7_arst_data", m_odata, DW'(0));
      chk("t7_arst_ch", DW'(m_och), DW'(0));
      tick();
      rst = 1'b0;
      tick();

      chk("main_sb_leftover", DW'(mq.size()), DW'(0));
      chk("fp_sb_leftover", DW'(fq.size()), DW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
